uart_tx_arb: RTL and testbench

- Packet-level arbiter and sequencer sharing one byte-serial UART transmitter among NREQ requesters, e.g. the fingerprint command sender and a debug/status sender.
- Grants one requester at a time, round-robin. Pulls its bytes one by one and issues one send_en pulse per byte. Waits for the transmitter's byte-done pulse before the next byte.
- Sits between the requesters and the UART TX + baud generator pair. Its send_en, data_rx and over_rx connect directly to those ports.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arb.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM encoding,
// byte width, default over_rx timeout and grant-index width helper.
package uart_pkg;

    localparam int          BYTE_W      = 8;
    localparam logic [31:0] TMO_CYC_DEF = 32'd2_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_CHK_H,
        ST_CHK_L,
        ST_DONE,
        ST_REL
    } state_e;

    // Which byte of the frame the current SEND/WAIT round carries.
    typedef enum logic [1:0] {
        PH_DATA,
        PH_CHK_H,
        PH_CHK_L
    } phase_e;

    // Requester counts 2..4 need a 1- or 2-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit searching upward
// from (rr_i + 1) mod NREQ with wrap-around.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] rr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IDX_W'((int'(rr_i) + i) % NREQ);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding one byte-serial UART transmitter.
// Define UART_ARB_CHKSUM_EN to append a 16-bit byte-sum checksum to each packet.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter logic [31:0] TMO_CYC = TMO_CYC_DEF,
    parameter int unsigned TMO_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    output logic [NREQ-1:0]        gnt,
    input  logic [NREQ*BYTE_W-1:0] din,
    input  logic [NREQ-1:0]        din_valid,
    input  logic [NREQ-1:0]        din_last,
    output logic [NREQ-1:0]        din_ready,
    output logic                   send_en,
    output logic [BYTE_W-1:0]      data_rx,
    input  logic                   over_rx,
    output logic [NREQ-1:0]        pkt_done,
    output logic                   tmo_err,
    output logic                   busy
);

    localparam int unsigned      IDX_W    = idx_width(NREQ);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 32'd1);

    state_e             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               last_q, last_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
`ifdef UART_ARB_CHKSUM_EN
    logic [15:0]        sum_q, sum_d;
    phase_e             phase_q, phase_d;
`endif

    logic [NREQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [BYTE_W-1:0]  din_g;
    logic               vld_g;
    logic               last_g;
    logic               tmo_hit;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (req),
        .rr_i  (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Only the granted requester's byte lane and qualifiers are ever looked at.
    always_comb begin
        din_g  = '0;
        vld_g  = 1'b0;
        last_g = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_q == IDX_W'(i)) begin
                din_g  = din[i*BYTE_W +: BYTE_W];
                vld_g  = din_valid[i];
                last_g = din_last[i];
            end
        end
    end

    // over_rx takes priority over a timeout landing in the same cycle.
    assign tmo_hit = (state_q == ST_WAIT) && (cnt_q == TMO_LAST) && !over_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_any) state_d = ST_LOAD;
            ST_LOAD: if (vld_g) state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (over_rx) begin
`ifdef UART_ARB_CHKSUM_EN
                    case (phase_q)
                        PH_DATA:  state_d = last_q ? ST_CHK_H : ST_LOAD;
                        PH_CHK_H: state_d = ST_CHK_L;
                        default:  state_d = ST_DONE;
                    endcase
`else
                    state_d = last_q ? ST_DONE : ST_LOAD;
`endif
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_REL;
                end
            end
`ifdef UART_ARB_CHKSUM_EN
            ST_CHK_H: state_d = ST_SEND;
            ST_CHK_L: state_d = ST_SEND;
`endif
            ST_DONE: state_d = ST_REL;
            ST_REL:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        send_en   = (state_q == ST_SEND);
        din_ready = (state_q == ST_LOAD && vld_g) ? gnt_q : '0;
        pkt_done  = (state_q == ST_DONE) ? gnt_q : '0;
        tmo_err   = tmo_hit;
        gnt       = gnt_q;
        busy      = |gnt_q;
        data_rx   = data_q;
    end

    always_comb begin
        gnt_d  = gnt_q;
        g_d    = g_q;
        rr_d   = rr_q;
        data_d = data_q;
        last_d = last_q;
        cnt_d  = cnt_q;
`ifdef UART_ARB_CHKSUM_EN
        sum_d   = sum_q;
        phase_d = phase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d = pick_gnt;
                    g_d   = pick_idx;
`ifdef UART_ARB_CHKSUM_EN
                    sum_d   = '0;
                    phase_d = PH_DATA;
`endif
                end
            end
            ST_LOAD: begin
                if (vld_g) begin
                    data_d = din_g;
                    last_d = last_g;
`ifdef UART_ARB_CHKSUM_EN
                    sum_d = sum_q + {8'h00, din_g};
`endif
                end
            end
            ST_SEND: cnt_d = '0;
            ST_WAIT: cnt_d = cnt_q + TMO_W'(1);
`ifdef UART_ARB_CHKSUM_EN
            ST_CHK_H: begin
                data_d  = sum_q[15:8];
                phase_d = PH_CHK_H;
            end
            ST_CHK_L: begin
                data_d  = sum_q[7:0];
                phase_d = PH_CHK_L;
            end
`endif
            ST_REL: rr_d = g_q;
            default: ;
        endcase
        // Grant is dropped on entry to REL so it is already low during REL.
        if (state_d == ST_REL) begin
            gnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= '0;
            g_q    <= '0;
            rr_q   <= IDX_W'(NREQ - 1);
            data_q <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
`ifdef UART_ARB_CHKSUM_EN
            sum_q   <= '0;
            phase_q <= PH_DATA;
`endif
        end else begin
            gnt_q  <= gnt_d;
            g_q    <= g_d;
            rr_q   <= rr_d;
            data_q <= data_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
`ifdef UART_ARB_CHKSUM_EN
            sum_q   <= sum_d;
            phase_q <= phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (NREQ=2, TMO_CYC=100).
// Handshake: a byte moves when din_valid[g] is seen in LOAD (din_ready pulses that cycle).
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [15:0] din;
    logic [1:0]  din_valid;
    logic [1:0]  din_last;
    logic [1:0]  din_ready;
    logic        send_en;
    logic [7:0]  data_rx;
    logic        over_rx;
    logic [1:0]  pkt_done;
    logic        tmo_err;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arb #(
        .NREQ    (2),
        .TMO_CYC (32'd100),
        .TMO_W   (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_ready (din_ready),
        .send_en   (send_en),
        .data_rx   (data_rx),
        .over_rx   (over_rx),
        .pkt_done  (pkt_done),
        .tmo_err   (tmo_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [1:0] oh(input int r);
        logic [1:0] v;
        v = 2'b01 << r;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte from requester r, then act as the UART: over_rx lat cycles later (lat=0: never).
    task automatic xfer_byte(input int r, input logic [7:0] b, input logic last, input int lat);
        int c;
        din[r*8 +: 8] = b;
        din_valid[r]  = 1'b1;
        din_last[r]   = last;
        #1;
        c = 0;
        while (din_ready[r] !== 1'b1 && c < 300) begin
            tick();
            c++;
        end
        chk("din_ready", {30'd0, din_ready}, {30'd0, oh(r)});
        tick();
        din_valid[r] = 1'b0;
        din_last[r]  = 1'b0;
        chk("send_en", {31'd0, send_en}, 32'd1);
        chk("data_rx", {24'd0, data_rx}, {24'd0, b});
        chk("gnt", {30'd0, gnt}, {30'd0, oh(r)});
        if (lat > 0) begin
            repeat (lat - 1) tick();
            chk("data_hold", {24'd0, data_rx}, {24'd0, b});
            over_rx = 1'b1;
            #1;
            chk("over_vs_tmo", {31'd0, tmo_err}, 32'd0);
            tick();
            over_rx = 1'b0;
        end
    endtask

`ifdef UART_ARB_CHKSUM_EN
    task automatic serve_byte(input logic [7:0] exp, input int lat);
        int c;
        c = 0;
        while (send_en !== 1'b1 && c < 300) begin
            tick();
            c++;
        end
        chk("chk_send_en", {31'd0, send_en}, 32'd1);
        chk("chk_data", {24'd0, data_rx}, {24'd0, exp});
        repeat (lat - 1) tick();
        over_rx = 1'b1;
        #1;
        chk("chk_over_vs_tmo", {31'd0, tmo_err}, 32'd0);
        tick();
        over_rx = 1'b0;
    endtask
`endif

    // Called on the cycle after the last data byte's over_rx.
    task automatic finish_pkt(input int r, input logic [15:0] sum, input int lat);
`ifdef UART_ARB_CHKSUM_EN
        serve_byte(sum[15:8], lat);
        serve_byte(sum[7:0], lat);
`endif
        chk("pkt_done", {30'd0, pkt_done}, {30'd0, oh(r)});
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        tick();
        chk("rel_outputs", {27'd0, busy, gnt, pkt_done}, 32'd0);
        tick();
        chk("idle_gnt", {30'd0, gnt}, 32'd0);
    endtask

    task automatic send_pkt(input int r, input int n, input logic [31:0] data, input int lat,
                            input bit keep_req);
        logic [15:0] sum;
        logic [7:0]  b;
        sum    = 16'h0000;
        req[r] = 1'b1;
        for (int i = 0; i < n; i++) begin
            b = data[8*i +: 8];
            xfer_byte(r, b, (i == n - 1), lat);
            sum = sum + {8'h00, b};
            if (i == 0 && !keep_req) req[r] = 1'b0;
        end
        finish_pkt(r, sum, lat);
    endtask

    initial begin
        int n;
        int bad;
        rst_n     = 1'b0;
        req       = 2'b00;
        din       = 16'h0000;
        din_valid = 2'b00;
        din_last  = 2'b00;
        over_rx   = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {15'd0, gnt, din_ready, send_en, data_rx, pkt_done, tmo_err, busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("reset_idle", {29'd0, busy, gnt}, 32'd0);

        // over_rx while idle
        over_rx = 1'b1;
        #1;
        chk("spurious_tmo", {30'd0, tmo_err, send_en}, 32'd0);
        tick();
        over_rx = 1'b0;
        chk("spurious_state", {27'd0, busy, gnt, pkt_done}, 32'd0);

        // Both requesting: 0 first after reset, then alternate
        req = 2'b11;
        send_pkt(0, 2, 32'h0000_1234, 10, 1'b1);
        send_pkt(1, 2, 32'h0000_5678, 10, 1'b1);
        send_pkt(0, 2, 32'h0000_9ABC, 10, 1'b0);
        send_pkt(1, 2, 32'h0000_DEF0, 10, 1'b0);

        // EF,01,FF with 20-cycle UART turnaround
        send_pkt(0, 3, 32'h00FF_01EF, 20, 1'b0);

        // Back-pressure on requester 1 while requester 0 offers a stray byte
        req[1] = 1'b1;
        xfer_byte(1, 8'hA5, 1'b0, 5);
        req[1] = 1'b0;
        din[7:0]     = 8'h77;
        din_valid[0] = 1'b1;
        din_last[0]  = 1'b1;
        bad = 0;
        repeat (50) begin
            tick();
            if (send_en !== 1'b0 || din_ready !== 2'b00 || data_rx !== 8'hA5 || busy !== 1'b1) bad++;
        end
        chk("bp_gap_violations", bad, 32'd0);
        din_valid[0] = 1'b0;
        din_last[0]  = 1'b0;
        xfer_byte(1, 8'h3C, 1'b1, 5);
        finish_pkt(1, 16'h00E1, 5);

        // No over_rx: abort after exactly 100 cycles
        req[0] = 1'b1;
        xfer_byte(0, 8'h11, 1'b1, 0);
        req[0] = 1'b0;
        n = 0;
        while (tmo_err !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 32'd100);
        chk("tmo_no_done", {30'd0, pkt_done}, 32'd0);
        tick();
        chk("tmo_rel", {26'd0, busy, gnt, tmo_err, pkt_done}, 32'd0);
        tick();
        send_pkt(1, 1, 32'h0000_005A, 20, 1'b0);

        // over_rx exactly on the timeout cycle
        send_pkt(0, 1, 32'h0000_0022, 101, 1'b0);

        // Reset during WAIT of the second byte
        req[1] = 1'b1;
        xfer_byte(1, 8'h31, 1'b0, 20);
        xfer_byte(1, 8'h32, 1'b0, 0);
        repeat (5) tick();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {15'd0, gnt, din_ready, send_en, data_rx, pkt_done, tmo_err, busy}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_gnt", {30'd0, gnt}, 32'd2);
        xfer_byte(1, 8'h42, 1'b1, 20);
        req[1] = 1'b0;
        finish_pkt(1, 16'h0042, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
